// File: rtl/lives_manager.sv
// Player life bookkeeping: hit/pickup handling, post-hit invulnerability window
// with sprite blinking, and an absorbing game-over state.
module lives_manager #(
    parameter int INIT_LIVES    = 3,
    parameter int MAX_LIVES     = 5,
    parameter int INVULN_FRAMES = 60,
    parameter int BLINK_FRAMES  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startOfFrame,
    input  logic       playerHit,
    input  logic       lifePickup,
    output logic [2:0] lives,
    output logic       gameOver,
    output logic       invulnerable,
    output logic       playerVisible
);

    typedef enum logic [1:0] {S_ALIVE, S_INVULN, S_DEAD} state_e;

    localparam logic [2:0] INIT_L = 3'(INIT_LIVES);
    localparam logic [2:0] MAX_L  = 3'(MAX_LIVES);
    localparam logic [7:0] INV_F  = 8'(INVULN_FRAMES);
    localparam logic [3:0] BLK_F  = 4'(BLINK_FRAMES);

    state_e     state_q, state_d;
    logic [2:0] lives_q, lives_d;
    logic [7:0] frame_q, frame_d;
    logic [3:0] blink_q, blink_d;
    logic       go_q, go_d;
    logic       inv_q, inv_d;
    logic       vis_q, vis_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_ALIVE;
            lives_q <= INIT_L;
            frame_q <= '0;
            blink_q <= '0;
            go_q    <= 1'b0;
            inv_q   <= 1'b0;
            vis_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            lives_q <= lives_d;
            frame_q <= frame_d;
            blink_q <= blink_d;
            go_q    <= go_d;
            inv_q   <= inv_d;
            vis_q   <= vis_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        frame_d = frame_q;
        blink_d = blink_q;
        go_d    = go_q;
        inv_d   = inv_q;
        vis_d   = vis_q;
        unique case (state_q)
            S_ALIVE: begin
                if (playerHit) begin
                    // A pickup in the same cycle cancels the hit's life cost but
                    // still grants the invulnerability window.
                    if (lifePickup || lives_q > 3'd1) begin
                        if (!lifePickup) lives_d = lives_q - 3'd1;
                        state_d = S_INVULN;
                        inv_d   = 1'b1;
                        vis_d   = 1'b0;
                        frame_d = INV_F;
                        blink_d = BLK_F;
                    end else begin
                        state_d = S_DEAD;
                        lives_d = '0;
                        go_d    = 1'b1;
                        vis_d   = 1'b0;
                    end
                end else if (lifePickup && lives_q < MAX_L) begin
                    lives_d = lives_q + 3'd1;
                end
            end
            S_INVULN: begin
                if (lifePickup && lives_q < MAX_L) lives_d = lives_q + 3'd1;
                if (startOfFrame) begin
                    if (frame_q == 8'd1) begin
                        state_d = S_ALIVE;
                        inv_d   = 1'b0;
                        vis_d   = 1'b1;
                        frame_d = '0;
                        blink_d = '0;
                    end else begin
                        frame_d = frame_q - 8'd1;
                        if (blink_q == 4'd1) begin
                            vis_d   = ~vis_q;
                            blink_d = BLK_F;
                        end else begin
                            blink_d = blink_q - 4'd1;
                        end
                    end
                end
            end
            S_DEAD: ;
            default: state_d = S_ALIVE;
        endcase
    end

    assign lives         = lives_q;
    assign gameOver      = go_q;
    assign invulnerable  = inv_q;
    assign playerVisible = vis_q;

endmodule

// File: tb/tb_lives_manager.sv
// Directed bench for lives_manager at default parameters; expected values are
// hand-computed constants.
module tb_lives_manager;

    logic       clk = 1'b0;
    logic       reset, startOfFrame, playerHit, lifePickup;
    logic [2:0] lives;
    logic       gameOver, invulnerable, playerVisible;

    int n_assert = 0;
    int n_fail   = 0;

    lives_manager dut (
        .clk          (clk),
        .reset        (reset),
        .startOfFrame (startOfFrame),
        .playerHit    (playerHit),
        .lifePickup   (lifePickup),
        .lives        (lives),
        .gameOver     (gameOver),
        .invulnerable (invulnerable),
        .playerVisible(playerVisible)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int l, input int g, input int inv, input int v);
        chk({tag, ".lives"}, int'(lives), l);
        chk({tag, ".gameOver"}, int'(gameOver), g);
        chk({tag, ".invulnerable"}, int'(invulnerable), inv);
        chk({tag, ".visible"}, int'(playerVisible), v);
    endtask

    // n frame pulses, each followed by one idle cycle
    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            startOfFrame = 1'b1; tick();
            startOfFrame = 1'b0; tick();
        end
    endtask

    initial begin
        reset = 1'b1; startOfFrame = 1'b0; playerHit = 1'b0; lifePickup = 1'b0;
        tick(); tick();
        chk_all("reset", 3, 0, 0, 1);
        reset = 1'b0;

        // First hit, then held high through the whole window.
        playerHit = 1'b1; tick();
        chk_all("hit1", 2, 0, 1, 0);
        for (int i = 1; i <= 60; i++) begin
            startOfFrame = 1'b1; tick();
            startOfFrame = 1'b0;
            if (i == 3)  chk("blink.f3", int'(playerVisible), 0);
            if (i == 4)  chk("blink.f4", int'(playerVisible), 1);
            if (i == 7)  chk("blink.f7", int'(playerVisible), 1);
            if (i == 8)  chk("blink.f8", int'(playerVisible), 0);
            if (i == 59) chk_all("held.f59", 2, 0, 1, 0);
            if (i == 60) chk_all("held.f60", 2, 0, 0, 1);
            tick();
            if (i == 30) chk("held.f30.lives", int'(lives), 2);
        end
        chk_all("held.rehit", 1, 0, 1, 0);
        playerHit = 1'b0;
        frames(60);
        chk_all("back.alive", 1, 0, 0, 1);

        // Hit and pickup together at one life: no death.
        playerHit = 1'b1; lifePickup = 1'b1; tick();
        playerHit = 1'b0; lifePickup = 1'b0;
        chk_all("hit+pick", 1, 0, 1, 0);
        frames(60);
        chk_all("alive2", 1, 0, 0, 1);

        // Fatal hit, then dead state ignores everything.
        playerHit = 1'b1; tick();
        playerHit = 1'b0;
        chk_all("death", 0, 1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            lifePickup = 1'b1; startOfFrame = 1'b1; playerHit = i[0]; tick();
            lifePickup = 1'b0; startOfFrame = 1'b0; playerHit = 1'b0; tick();
        end
        chk_all("dead.hold", 0, 1, 0, 0);

        // Reset out of dead, pickup saturation.
        reset = 1'b1; tick(); reset = 1'b0;
        chk_all("reset.dead", 3, 0, 0, 1);
        lifePickup = 1'b1; tick(); tick();
        chk("pick.5", int'(lives), 5);
        tick(); tick(); tick();
        lifePickup = 1'b0;
        chk("pick.sat", int'(lives), 5);

        // Pickup inside invulnerability, then reset mid-window.
        playerHit = 1'b1; tick(); playerHit = 1'b0;
        chk_all("hit.max", 4, 0, 1, 0);
        lifePickup = 1'b1; tick(); lifePickup = 1'b0;
        chk("inv.pick", int'(lives), 5);
        frames(5);
        chk_all("inv.mid", 5, 0, 1, 1);
        reset = 1'b1; tick(); reset = 1'b0;
        chk_all("reset.inv", 3, 0, 0, 1);
        playerHit = 1'b1; tick(); playerHit = 1'b0;
        chk_all("hit.after.reset", 2, 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
